// File: rtl/pe_network_interface.sv
// rtl/pe_network_interface.sv - PE-side network interface: flit packing, credit-controlled injection, eject receive FIFO
module pe_network_interface #(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int CREDITS  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] tx_data,
  input  logic [1:0]  tx_dst_cluster,
  input  logic [1:0]  tx_dst_local,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [19:0] inject,
  output logic        inject_valid,
  input  logic        credit_in,
  input  logic [19:0] eject,
  input  logic        eject_valid,
  output logic [19:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_pop,
  output logic [15:0] read,
  output logic        rx_overflow,
  output logic        credit_err,
  output logic [15:0] tx_count,
  output logic [15:0] rx_count
);
  localparam int TXW = $clog2(TX_DEPTH);
  localparam int RXW = $clog2(RX_DEPTH);
  localparam int CW  = $clog2(CREDITS + 1);
  localparam logic [TXW:0]  TX_FULL_CNT = (TXW + 1)'(TX_DEPTH);
  localparam logic [RXW:0]  RX_FULL_CNT = (RXW + 1)'(RX_DEPTH);
  localparam logic [CW-1:0] CRED_MAX    = CW'(CREDITS);

  logic [19:0]    tx_mem [TX_DEPTH];
  logic [19:0]    rx_mem [RX_DEPTH];
  logic [TXW-1:0] tx_wr, tx_rd;
  logic [RXW-1:0] rx_wr, rx_rd;
  logic [TXW:0]   tx_cnt;
  logic [RXW:0]   rx_cnt;
  logic [CW-1:0]  credits;
  logic           tx_push, do_send, rx_push, rx_pop_eff;

  assign tx_ready   = (tx_cnt != TX_FULL_CNT);
  assign tx_push    = tx_valid && tx_ready;
  assign do_send    = (tx_cnt != '0) && (credits != '0);
  assign rx_valid   = (rx_cnt != '0);
  assign rx_data    = rx_mem[rx_rd];
  assign rx_pop_eff = rx_pop && rx_valid;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign rx_push    = eject_valid && ((rx_cnt != RX_FULL_CNT) || rx_pop);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= {tx_dst_cluster, tx_dst_local, tx_data};
    if (rx_push) rx_mem[rx_wr] <= eject;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr        <= '0;
      tx_rd        <= '0;
      tx_cnt       <= '0;
      rx_wr        <= '0;
      rx_rd        <= '0;
      rx_cnt       <= '0;
      credits      <= CRED_MAX;
      inject       <= '0;
      inject_valid <= 1'b0;
      read         <= '0;
      rx_overflow  <= 1'b0;
      credit_err   <= 1'b0;
      tx_count     <= '0;
      rx_count     <= '0;
    end else begin
      inject_valid <= do_send;
      if (tx_push) tx_wr <= tx_wr + TXW'(1);
      if (do_send) begin
        inject   <= tx_mem[tx_rd];
        tx_rd    <= tx_rd + TXW'(1);
        tx_count <= tx_count + 16'd1;
      end
      if (tx_push && !do_send)      tx_cnt <= tx_cnt + (TXW + 1)'(1);
      else if (!tx_push && do_send) tx_cnt <= tx_cnt - (TXW + 1)'(1);

      // A returned credit in a sending cycle cancels the spend.
      if (do_send && !credit_in) begin
        credits <= credits - CW'(1);
      end else if (!do_send && credit_in) begin
        if (credits == CRED_MAX) credit_err <= 1'b1;
        else                     credits    <= credits + CW'(1);
      end

      if (eject_valid) read <= eject[15:0];
      if (eject_valid && !rx_push) rx_overflow <= 1'b1;
      if (rx_push) begin
        rx_wr    <= rx_wr + RXW'(1);
        rx_count <= rx_count + 16'd1;
      end
      if (rx_pop_eff) rx_rd <= rx_rd + RXW'(1);
      if (rx_push && !rx_pop_eff)      rx_cnt <= rx_cnt + (RXW + 1)'(1);
      else if (!rx_push && rx_pop_eff) rx_cnt <= rx_cnt - (RXW + 1)'(1);
    end
  end
endmodule

// File: tb/tb_pe_network_interface.sv
// tb/tb_pe_network_interface.sv - self-checking bench for pe_network_interface
module tb_pe_network_interface;
  localparam int TXD = 4, RXD = 4, CRED = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] tx_data = '0;
  logic [1:0]  tx_dst_cluster = '0, tx_dst_local = '0;
  logic        tx_valid = 1'b0, tx_ready;
  logic [19:0] inject;
  logic        inject_valid, credit_in = 1'b0;
  logic [19:0] eject = '0;
  logic        eject_valid = 1'b0;
  logic [19:0] rx_data;
  logic        rx_valid, rx_pop = 1'b0;
  logic [15:0] read;
  logic        rx_overflow, credit_err;
  logic [15:0] tx_count, rx_count;

  int npass = 0, ntotal = 0;
  logic [19:0] got[$];

  pe_network_interface #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .CREDITS(CRED)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_dst_cluster(tx_dst_cluster),
    .tx_dst_local(tx_dst_local), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .inject(inject), .inject_valid(inject_valid), .credit_in(credit_in),
    .eject(eject), .eject_valid(eject_valid), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_pop(rx_pop), .read(read), .rx_overflow(rx_overflow), .credit_err(credit_err),
    .tx_count(tx_count), .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ev;
    logic [19:0] ej;
    logic        pop;
    logic        exp_valid;
    logic [19:0] exp_data;
    logic [15:0] exp_read;
    logic        exp_ovf;
    logic [15:0] exp_cnt;
  } rx_vec_t;
  rx_vec_t tbl[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (inject_valid) got.push_back(inject);
  endtask

  task automatic clear_inputs();
    tx_valid = 0; credit_in = 0; eject_valid = 0; rx_pop = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    got.delete();
  endtask

  task automatic set_push(input logic [15:0] d, input logic [1:0] c, input logic [1:0] l);
    tx_valid = 1; tx_data = d; tx_dst_cluster = c; tx_dst_local = l;
  endtask

  // Reference model state
  logic [19:0] mtx[$], mrx[$];
  int          mcred;
  logic [19:0] m_inject;
  logic        m_iv, m_ovf, m_cerr;
  logic [15:0] m_read, m_txc, m_rxc;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 20'h0,     1'b0, 1'b0, 20'h0,     16'h0,  1'b0, 16'd0};
    tbl[1]  = '{1'b0, 1'b1, 20'hA0001, 1'b0, 1'b1, 20'hA0001, 16'h1,  1'b0, 16'd1};
    tbl[2]  = '{1'b0, 1'b1, 20'hA0002, 1'b0, 1'b1, 20'hA0001, 16'h2,  1'b0, 16'd2};
    tbl[3]  = '{1'b0, 1'b1, 20'hA0003, 1'b0, 1'b1, 20'hA0001, 16'h3,  1'b0, 16'd3};
    tbl[4]  = '{1'b0, 1'b1, 20'hA0004, 1'b0, 1'b1, 20'hA0001, 16'h4,  1'b0, 16'd4};
    tbl[5]  = '{1'b0, 1'b1, 20'hA0005, 1'b0, 1'b1, 20'hA0001, 16'h5,  1'b1, 16'd4};
    tbl[6]  = '{1'b1, 1'b0, 20'h0,     1'b0, 1'b0, 20'h0,     16'h0,  1'b0, 16'd0};
    tbl[7]  = '{1'b0, 1'b1, 20'hA0011, 1'b0, 1'b1, 20'hA0011, 16'h11, 1'b0, 16'd1};
    tbl[8]  = '{1'b0, 1'b1, 20'hA0012, 1'b0, 1'b1, 20'hA0011, 16'h12, 1'b0, 16'd2};
    tbl[9]  = '{1'b0, 1'b1, 20'hA0013, 1'b0, 1'b1, 20'hA0011, 16'h13, 1'b0, 16'd3};
    tbl[10] = '{1'b0, 1'b1, 20'hA0014, 1'b0, 1'b1, 20'hA0011, 16'h14, 1'b0, 16'd4};
    tbl[11] = '{1'b0, 1'b1, 20'hA0015, 1'b1, 1'b1, 20'hA0012, 16'h15, 1'b0, 16'd5};
    tbl[12] = '{1'b0, 1'b0, 20'h0,     1'b1, 1'b1, 20'hA0013, 16'h15, 1'b0, 16'd5};
    tbl[13] = '{1'b0, 1'b0, 20'h0,     1'b1, 1'b1, 20'hA0014, 16'h15, 1'b0, 16'd5};
    tbl[14] = '{1'b0, 1'b0, 20'h0,     1'b1, 1'b1, 20'hA0015, 16'h15, 1'b0, 16'd5};
    tbl[15] = '{1'b0, 1'b0, 20'h0,     1'b1, 1'b0, 20'h0,     16'h15, 1'b0, 16'd5};
    tbl[16] = '{1'b0, 1'b0, 20'h0,     1'b1, 1'b0, 20'h0,     16'h15, 1'b0, 16'd5};
    tbl[17] = '{1'b0, 1'b1, 20'hA0020, 1'b1, 1'b1, 20'hA0020, 16'h20, 1'b0, 16'd6};

    // Reset state
    #1;
    chk("rst_inject", inject, 0);
    chk("rst_inject_valid", inject_valid, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_read", read, 0);
    chk("rst_flags", {rx_overflow, credit_err}, 0);
    chk("rst_counts", {tx_count, rx_count}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single push: minimum latency and one-cycle valid
    set_push(16'hBEEF, 2'd2, 2'd1);
    step();
    tx_valid = 0;
    chk("single_not_yet", inject_valid, 0);
    step();
    chk("single_inject", inject, 20'h9BEEF);
    chk("single_valid", inject_valid, 1);
    chk("single_tx_count", tx_count, 1);
    step();
    chk("single_valid_drop", inject_valid, 0);
    chk("single_inject_hold", inject, 20'h9BEEF);

    // Six pushes, four credits
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_push(16'h0100 + 16'(i), 2'd0, 2'd0);
      chk($sformatf("burst_tx_ready%0d", i), tx_ready, 1);
      step();
    end
    tx_valid = 0;
    for (int i = 0; i < 4; i++) step();
    chk("burst_injected", got.size(), 4);
    chk("burst_tx_count", tx_count, 4);
    chk("burst_idle", inject_valid, 0);
    for (int i = 0; i < 2; i++) begin
      credit_in = 1; step(); credit_in = 0; step();
    end
    step();
    chk("burst_tx_count_final", tx_count, 6);
    chk("burst_all", got.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < got.size()) chk($sformatf("burst_order%0d", i), got[i], 20'h00100 + 20'(i));
    chk("burst_no_cerr", credit_err, 0);

    // Credit returned in the same cycle as a send with counter=1
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      set_push(16'(i), 2'd1, 2'd3);
      credit_in = (i == 5);
      step();
    end
    clear_inputs();
    for (int i = 0; i < 3; i++) step();
    chk("simul_tx_count", tx_count, 5);
    chk("simul_last", inject, 20'h70005);
    chk("simul_no_cerr", credit_err, 0);
    set_push(16'h0006, 2'd0, 2'd0);
    step();
    tx_valid = 0;
    step(); step();
    chk("zero_credit_hold", tx_count, 5);
    credit_in = 1; step(); credit_in = 0; step();
    chk("zero_credit_resume", tx_count, 6);

    // Extra credit at full count
    do_reset();
    credit_in = 1; step(); credit_in = 0;
    chk("credit_err_set", credit_err, 1);
    step();
    chk("credit_err_sticky", credit_err, 1);

    // Receive table
    foreach (tbl[i]) begin
      if (tbl[i].rst) begin
        @(negedge clk);
        rst = 1'b1;
        #1;
      end else begin
        eject_valid = tbl[i].ev; eject = tbl[i].ej; rx_pop = tbl[i].pop;
        step();
        clear_inputs();
      end
      chk($sformatf("rx%0d_valid", i), rx_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) chk($sformatf("rx%0d_data", i), rx_data, tbl[i].exp_data);
      chk($sformatf("rx%0d_read", i), read, tbl[i].exp_read);
      chk($sformatf("rx%0d_ovf", i), rx_overflow, tbl[i].exp_ovf);
      chk($sformatf("rx%0d_cnt", i), rx_count, tbl[i].exp_cnt);
      if (tbl[i].rst) begin
        @(negedge clk);
        rst = 1'b0;
      end
    end

    // Reset mid-stream with flits queued
    do_reset();
    for (int i = 0; i < 7; i++) begin
      set_push(16'h0200 + 16'(i), 2'd3, 2'd3);
      eject_valid = (i == 0); eject = 20'h12345;
      step();
    end
    clear_inputs();
    step(); step();
    chk("mid_pre_count", tx_count, 4);
    rst = 1'b1;
    #1;
    chk("mid_inject", inject, 0);
    chk("mid_valid", inject_valid, 0);
    chk("mid_tx_count", tx_count, 0);
    chk("mid_rx", {rx_valid, read, rx_count}, 0);
    @(negedge clk);
    rst = 1'b0;
    got.delete();
    for (int i = 0; i < 5; i++) begin
      set_push(16'hCAF0 + 16'(i), 2'd0, 2'd0);
      step();
      if (i == 1) chk("mid_first_latency", got.size(), 1);
    end
    tx_valid = 0;
    for (int i = 0; i < 4; i++) step();
    chk("mid_four_credits", tx_count, 4);
    if (got.size() > 0) chk("mid_first_flit", got[0], 20'h0CAF0);

    // Randomized run against reference model
    do_reset();
    mtx.delete(); mrx.delete();
    mcred = CRED; m_inject = 0; m_iv = 0; m_ovf = 0; m_cerr = 0;
    m_read = 0; m_txc = 0; m_rxc = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic        ready_pre, send, accept;
      logic [19:0] flit;
      tx_valid = ($urandom_range(0, 9) < 6);
      tx_data = 16'($urandom);
      tx_dst_cluster = 2'($urandom);
      tx_dst_local = 2'($urandom);
      credit_in = ($urandom_range(0, 9) < 3);
      eject_valid = ($urandom_range(0, 1) == 1);
      eject = 20'($urandom);
      rx_pop = ($urandom_range(0, 9) < 4);
      ready_pre = (mtx.size() < TXD);
      chk("rnd_tx_ready", tx_ready, ready_pre);

      send = (mtx.size() > 0) && (mcred > 0);
      m_iv = send;
      if (send) begin
        m_inject = mtx.pop_front();
        m_txc++;
      end
      if (tx_valid && ready_pre) mtx.push_back({tx_dst_cluster, tx_dst_local, tx_data});
      mcred = mcred - int'(send) + int'(credit_in);
      if (mcred > CRED) begin
        mcred = CRED;
        m_cerr = 1;
      end
      accept = eject_valid && (mrx.size() < RXD || rx_pop);
      if (eject_valid) m_read = eject[15:0];
      if (eject_valid && !accept) m_ovf = 1;
      if (rx_pop && mrx.size() > 0) flit = mrx.pop_front();
      if (accept) begin
        mrx.push_back(eject);
        m_rxc++;
      end

      step();
      clear_inputs();
      chk("rnd_inject_valid", inject_valid, m_iv);
      chk("rnd_inject", inject, m_inject);
      chk("rnd_rx_valid", rx_valid, mrx.size() > 0);
      if (mrx.size() > 0) chk("rnd_rx_data", rx_data, mrx[0]);
      chk("rnd_read", read, m_read);
      chk("rnd_flags", {rx_overflow, credit_err}, {m_ovf, m_cerr});
      chk("rnd_counts", {tx_count, rx_count}, {m_txc, m_rxc});
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
